spi_frame_arbiter: RTL

- Synthesizable SPI master for the GT8305 command interface.
- Arbitrates between two on-chip requesters and serialises one command+data frame per grant over a single SPI bus.
- SPI timing (clock phases, chip-select setup, hold and high gap) is expressed in sys_clk cycles.
- SPI mode 0; frame = CMD_WIDTH-bit command (MSB=1 read, 0 write) followed by DATA_WIDTH data bits, MSB first.

---
 rtl/spi_frame_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_arbiter.sv
// spi_frame_arbiter: two-requester arbiter feeding a mode-0 SPI master.
// Each grant serialises one {command, data} frame MSB first; all SPI
// timing is counted in sys_clk cycles. Read frames send zeros in the data
// field and return the last DATA_WIDTH received bits on rdata.
module spi_frame_arbiter #(
   parameter int CMD_WIDTH  = 5,
   parameter int DATA_WIDTH = 11,
   parameter int CLKL_CYC   = 4,
   parameter int CLKH_CYC   = 4,
   parameter int SU_SCS_CYC = 5,
   parameter int HD_SCS_CYC = 5,
   parameter int HI_SCS_CYC = 40
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic [CMD_WIDTH-1:0]  cmd0,
   input  logic [CMD_WIDTH-1:0]  cmd1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  done0,
   output logic                  done1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  spi_cs_n,
   output logic                  spi_sclk,
   output logic                  spi_mosi,
   input  logic                  spi_miso
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int FRAME_W = CMD_WIDTH + DATA_WIDTH;
   localparam int MAX_CYC = max2(max2(max2(CLKL_CYC, CLKH_CYC), max2(SU_SCS_CYC, HD_SCS_CYC)), HI_SCS_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int BIT_W   = $clog2(FRAME_W + 1);

   localparam logic [CNT_W-1:0] SU_LAST = CNT_W'(SU_SCS_CYC - 1);
   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(CLKH_CYC - 1);
   localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(CLKL_CYC - 1);
   localparam logic [CNT_W-1:0] HD_LAST = CNT_W'(HD_SCS_CYC - 1);
   localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HI_SCS_CYC - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 gnt_q, gnt_d;
   logic                 last_q, last_d;
   logic                 rd_q, rd_d;
   logic                 cs_n_d, sclk_d, mosi_d, busy_d, done0_d, done1_d;
   logic [DATA_WIDTH-1:0] rdata_d;

   // Bits still to be sent after the one currently on mosi, and received bits.
   logic [FRAME_W-2:0]    tx_sr;
   logic [DATA_WIDTH-1:0] rx_sr;
   logic                  load_tx, shift_en;

   // Round-robin pick: on a tie the requester not served last wins.
   logic                  sel_gnt, sel_rd;
   logic [CMD_WIDTH-1:0]  sel_cmd;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [FRAME_W-1:0]    sel_frame;

   assign sel_gnt   = (req0 && req1) ? ~last_q : req1;
   assign sel_cmd   = sel_gnt ? cmd1 : cmd0;
   assign sel_wdata = sel_gnt ? wdata1 : wdata0;
   assign sel_rd    = sel_cmd[CMD_WIDTH-1];
   assign sel_frame = {sel_cmd, (sel_rd ? {DATA_WIDTH{1'b0}} : sel_wdata)};

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      rd_d      = rd_q;
      cs_n_d    = spi_cs_n;
      sclk_d    = spi_sclk;
      mosi_d    = spi_mosi;
      busy_d    = busy;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      rdata_d   = rdata;
      load_tx   = 1'b0;
      shift_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               gnt_d     = sel_gnt;
               last_d    = sel_gnt;
               rd_d      = sel_rd;
               load_tx   = 1'b1;
               cs_n_d    = 1'b0;
               mosi_d    = sel_frame[FRAME_W-1];
               busy_d    = 1'b1;
               cnt_d     = '0;
               bit_cnt_d = '0;
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == SU_LAST) begin
               sclk_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_HIGH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HIGH: begin
            if (cnt_q == H_LAST) begin
               sclk_d    = 1'b0;
               shift_en  = 1'b1;
               cnt_d     = '0;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = ST_HOLD;
               end else begin
                  mosi_d  = tx_sr[FRAME_W-2];
                  state_d = ST_LOW;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_LOW: begin
            if (cnt_q == L_LAST) begin
               sclk_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_HIGH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == HD_LAST) begin
               cs_n_d  = 1'b1;
               done0_d = ~gnt_q;
               done1_d = gnt_q;
               if (rd_q) rdata_d = rx_sr;
               cnt_d   = '0;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == HI_LAST) begin
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and output registers; reset returns the bus to idle at once.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
         rd_q      <= 1'b0;
         spi_cs_n  <= 1'b1;
         spi_sclk  <= 1'b0;
         spi_mosi  <= 1'b0;
         busy      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         rdata     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         rd_q      <= rd_d;
         spi_cs_n  <= cs_n_d;
         spi_sclk  <= sclk_d;
         spi_mosi  <= mosi_d;
         busy      <= busy_d;
         done0     <= done0_d;
         done1     <= done1_d;
         rdata     <= rdata_d;
      end
   end

   // Shift datapath: transmit remainder shifts out, miso shifts in on sclk fall.
   always_ff @(posedge sys_clk) begin
      if (load_tx) begin
         tx_sr <= sel_frame[FRAME_W-2:0];
      end else if (shift_en) begin
         tx_sr <= {tx_sr[FRAME_W-3:0], 1'b0};
      end
      if (shift_en) begin
         rx_sr <= {rx_sr[DATA_WIDTH-2:0], spi_miso};
      end
   end

endmodule
